// File: rtl/md_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: operation
// encoding, FSM states, datapath width and iteration count.
package md_pkg;

  localparam int MD_XLEN  = 32;
  localparam int MD_ITERS = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } md_state_e;

  // rs1 is interpreted as two's complement for these ops
  function automatic logic op_a_signed(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  // rs2 is interpreted as two's complement for these ops
  function automatic logic op_b_signed(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/md_div_iter.sv
// One restoring-division step: shift the next dividend bit into the
// partial remainder, try to subtract the divisor, keep the difference
// and record a 1 quotient bit if it did not go negative.
module md_div_iter
  import md_pkg::*;
(
  input  logic [MD_XLEN-1:0] rem,
  input  logic [MD_XLEN-1:0] quot,
  input  logic [MD_XLEN-1:0] divisor,
  output logic [MD_XLEN-1:0] rem_next,
  output logic [MD_XLEN-1:0] quot_next
);

  logic [MD_XLEN:0] shifted;
  logic [MD_XLEN:0] diff;

  // trial subtraction; bit MD_XLEN of diff is the borrow
  always_comb begin
    shifted = {rem, quot[MD_XLEN-1]};
    diff    = shifted - {1'b0, divisor};
    if (!diff[MD_XLEN]) begin
      rem_next  = diff[MD_XLEN-1:0];
      quot_next = {quot[MD_XLEN-2:0], 1'b1};
    end else begin
      rem_next  = shifted[MD_XLEN-1:0];
      quot_next = {quot[MD_XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/md_unit.sv
// RV32M multiply/divide unit. Iterative shift-add multiply and restoring
// divide on operand magnitudes, sign fix-up in FIN, registered results.
// Define MD_FAST_MUL_EN to replace the iterative multiply with a
// single-cycle 64-bit multiplier (divides stay iterative).
module md_unit
  import md_pkg::*;
#(
  parameter int XLEN = MD_XLEN
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [4:0]      rd_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_o,
  output logic            wen_o
);

  localparam logic [4:0] LAST_ITER = 5'(MD_ITERS - 1);

  md_state_e       state_q, state_d;
  md_op_e          op_q;
  logic [4:0]      rd_q;
  logic [4:0]      cnt_q;
  logic [XLEN-1:0] b_q;
  logic [XLEN-1:0] hi_q, lo_q;
  logic            neg_q, neg_r;

  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf, fast_mul;
  logic [XLEN:0]   mul_sum;
  logic [XLEN-1:0] div_rem, div_quot;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0] fin_result;
`ifdef MD_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
`endif

  // operand decode at accept time: magnitudes and the short-cut cases
  always_comb begin
    a_neg    = op_a_signed(op_i) & rs1_data_i[XLEN-1];
    b_neg    = op_b_signed(op_i) & rs2_data_i[XLEN-1];
    a_mag    = a_neg ? -rs1_data_i : rs1_data_i;
    b_mag    = b_neg ? -rs2_data_i : rs2_data_i;
    div_zero = op_i[2] && (rs2_data_i == '0);
    div_ovf  = ((op_i == OP_DIV) || (op_i == OP_REM)) &&
               (rs1_data_i == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_data_i == '1);
`ifdef MD_FAST_MUL_EN
    fast_mul  = !op_i[2];
    fast_prod = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
`else
    fast_mul  = 1'b0;
`endif
  end

  // one shift-add multiply step: conditionally add multiplicand, shift right
  always_comb begin
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
  end

  md_div_iter u_div_iter (
    .rem       (hi_q),
    .quot      (lo_q),
    .divisor   (b_q),
    .rem_next  (div_rem),
    .quot_next (div_quot)
  );

  // sign correction and result selection used when leaving FIN
  always_comb begin
    prod_fix = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    case (op_q)
      OP_MUL:                      fin_result = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fin_result = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:             fin_result = neg_q ? -lo_q : lo_q;
      default:                     fin_result = neg_r ? -hi_q : hi_q;
    endcase
  end

  // state register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // next-state logic; divide corner cases and fast multiply skip CALC
  always_comb begin
    state_d = state_q;
    busy_o  = (state_q != IDLE);
    case (state_q)
      IDLE: if (start_i) state_d = (div_zero || div_ovf || fast_mul) ? FIN : CALC;
      CALC: if (cnt_q == LAST_ITER) state_d = FIN;
      FIN:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // datapath: capture on accept, iterate in CALC, publish from FIN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op_q     <= OP_MUL;
      rd_q     <= '0;
      cnt_q    <= '0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      done_o   <= 1'b0;
      wen_o    <= 1'b0;
      result_o <= '0;
      rd_o     <= '0;
    end else begin
      done_o <= 1'b0;
      wen_o  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            op_q  <= md_op_e'(op_i);
            rd_q  <= rd_i;
            cnt_q <= '0;
            b_q   <= b_mag;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
            if (div_zero) begin
              hi_q  <= rs1_data_i;
              lo_q  <= '1;
              neg_q <= 1'b0;
              neg_r <= 1'b0;
            end else if (div_ovf) begin
              hi_q  <= '0;
              lo_q  <= {1'b1, {(XLEN-1){1'b0}}};
              neg_q <= 1'b0;
              neg_r <= 1'b0;
`ifdef MD_FAST_MUL_EN
            end else if (fast_mul) begin
              {hi_q, lo_q} <= fast_prod;
`endif
            end else begin
              hi_q <= '0;
              lo_q <= a_mag;
            end
          end
        end
        CALC: begin
          cnt_q <= cnt_q + 5'd1;
          if (op_q[2]) begin
            hi_q <= div_rem;
            lo_q <= div_quot;
          end else begin
            hi_q <= mul_sum[XLEN:1];
            lo_q <= {mul_sum[0], lo_q[XLEN-1:1]};
          end
        end
        FIN: begin
          done_o   <= 1'b1;
          wen_o    <= (rd_q != 5'd0);
          result_o <= fin_result;
          rd_o     <= rd_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit with hand-computed results.
module tb_md_unit;

  localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
  localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;

`ifdef MD_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [2:0]  op_i = '0;
  logic [31:0] rs1_data_i = '0;
  logic [31:0] rs2_data_i = '0;
  logic [4:0]  rd_i = '0;
  logic        busy_o, done_o, wen_o;
  logic [31:0] result_o;
  logic [4:0]  rd_o;

  int total = 0;
  int bad   = 0;

  md_unit dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .op_i       (op_i),
    .rs1_data_i (rs1_data_i),
    .rs2_data_i (rs2_data_i),
    .rd_i       (rd_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .result_o   (result_o),
    .rd_o       (rd_o),
    .wen_o      (wen_o)
  );

  // free-running clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // drive one request, accept it at the next edge, then wait for done_o
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] rd, output int lat);
    op_i = op; rs1_data_i = a; rs2_data_i = b; rd_i = rd; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    lat = 999;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if (done_o) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic runOp(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd,
                       input logic [31:0] exp, input int exp_lat);
    int lat;
    applyStimulus(op, a, b, rd, lat);
    checkOutput({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    checkOutput({tag, "_res"}, result_o, exp);
    checkOutput({tag, "_rd"}, {27'd0, rd_o}, {27'd0, rd});
    checkOutput({tag, "_wen"}, {31'd0, wen_o}, {31'd0, (rd != 5'd0)});
    checkOutput({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
  endtask

  // global time limit so the run always ends
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat, seen;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_busy", {31'd0, busy_o}, 32'd0);
    checkOutput("rst_done", {31'd0, done_o}, 32'd0);
    checkOutput("rst_wen", {31'd0, wen_o}, 32'd0);
    checkOutput("rst_result", result_o, 32'd0);
    checkOutput("rst_rd", {27'd0, rd_o}, 32'd0);
    rst_i = 1'b0;
    @(posedge clk); #1;

    // start with rst_i high is ignored
    rst_i = 1'b1; start_i = 1'b1; op_i = DIVU; rs1_data_i = 32'd9; rs2_data_i = 32'd3;
    @(posedge clk); #1;
    rst_i = 1'b0; start_i = 1'b0;
    checkOutput("rst_prio_busy", {31'd0, busy_o}, 32'd0);

    // back-to-back sequence: each op starts in the previous done cycle
    runOp("mul", MUL, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, MUL_LAT);
    runOp("mulhu", MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'hFFFF_FFFE, MUL_LAT);
    runOp("mulh", MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'h0000_0000, MUL_LAT);
    runOp("mulhsu", MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 32'hFFFF_FFFF, MUL_LAT);
    runOp("mulh_big", MULH, 32'h1234_5678, 32'h0001_0000, 5'd9, 32'h0000_1234, MUL_LAT);
    runOp("div", DIV, 32'hFFFF_FFF9, 32'd2, 5'd10, 32'hFFFF_FFFD, DIV_LAT);
    runOp("rem", REM, 32'hFFFF_FFF9, 32'd2, 5'd11, 32'hFFFF_FFFF, DIV_LAT);
    runOp("divu", DIVU, 32'd100, 32'd7, 5'd12, 32'd14, DIV_LAT);
    runOp("remu", REMU, 32'd100, 32'd7, 5'd13, 32'd2, DIV_LAT);
    runOp("div_negdiv", DIV, 32'd7, 32'hFFFF_FFFE, 5'd14, 32'hFFFF_FFFD, DIV_LAT);
    runOp("divu_zero", DIVU, 32'd5, 32'd0, 5'd15, 32'hFFFF_FFFF, 1);
    runOp("rem_zero", REM, 32'hFFFF_FFF9, 32'd0, 5'd16, 32'hFFFF_FFF9, 1);
    runOp("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'h8000_0000, 1);
    runOp("rem_ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 32'h0000_0000, 1);
    runOp("mul_rd0", MUL, 32'd3, 32'd4, 5'd0, 32'd12, MUL_LAT);

    // start held high through CALC with other operands: only the first op runs
    op_i = DIVU; rs1_data_i = 32'd100; rs2_data_i = 32'd7; rd_i = 5'd3; start_i = 1'b1;
    @(posedge clk); #1;
    checkOutput("hold_busy", {31'd0, busy_o}, 32'd1);
    op_i = REMU; rs1_data_i = 32'd50; rs2_data_i = 32'd5; rd_i = 5'd9;
    lat = 999;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if (done_o) begin
        lat = k;
        break;
      end
    end
    start_i = 1'b0;
    checkOutput("hold_lat", 32'(lat), 32'(DIV_LAT));
    checkOutput("hold_res", result_o, 32'd14);
    checkOutput("hold_rd", {27'd0, rd_o}, 32'd3);
    @(posedge clk); #1;
    checkOutput("hold_noqueue", {31'd0, busy_o}, 32'd0);

    // reset at CALC cycle 10 aborts without any write
    op_i = DIVU; rs1_data_i = 32'd100; rs2_data_i = 32'd7; rd_i = 5'd4; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    checkOutput("abort_busy", {31'd0, busy_o}, 32'd0);
    checkOutput("abort_done", {31'd0, done_o}, 32'd0);
    checkOutput("abort_wen", {31'd0, wen_o}, 32'd0);
    checkOutput("abort_result", result_o, 32'd0);
    checkOutput("abort_rd", {27'd0, rd_o}, 32'd0);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done_o || wen_o || busy_o) seen++;
    end
    checkOutput("abort_quiet", 32'(seen), 32'd0);
    runOp("after_abort", REMU, 32'd100, 32'd7, 5'd20, 32'd2, DIV_LAT);

    // reset coinciding with FIN suppresses done and write
    op_i = DIVU; rs1_data_i = 32'd100; rs2_data_i = 32'd7; rd_i = 5'd21; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (32) @(posedge clk);
    #1;
    checkOutput("fin_state_busy", {31'd0, busy_o}, 32'd1);
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    checkOutput("finrst_done", {31'd0, done_o}, 32'd0);
    checkOutput("finrst_wen", {31'd0, wen_o}, 32'd0);
    checkOutput("finrst_busy", {31'd0, busy_o}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/md_unit.md
MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 SHALL have parameter: XLEN, 32, operand/result width; only 32 is supported.
REQ-002 SHALL have port: clk_i  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have port: rst_i  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port: start_i  input  1  request to begin an operation.
REQ-005 SHALL have port: op_i  input  3  RV32M funct3: MUL=0, MULH=1, MULHSU=2, MULHU=3, DIV=4, DIVU=5, REM=6, REMU=7.
REQ-006 SHALL have port: rs1_data_i  input  32  operand A, from register file read port 1.
REQ-007 SHALL have port: rs2_data_i  input  32  operand B, from register file read port 2.
REQ-008 SHALL have port: rd_i  input  5  destination register index.
REQ-009 SHALL have port: busy_o  output  1  operation in progress; start_i ignored while high.
REQ-010 SHALL have port: done_o  output  1  one-cycle pulse; result_o/rd_o valid.
REQ-011 SHALL have port: result_o  output  32  result, drives register file write data.
REQ-012 SHALL have port: rd_o  output  5  write index, drives register file write address.
REQ-013 SHALL have port: wen_o  output  1  register file write enable.

Function
REQ-014 SHALL implement FSM states IDLE, CALC, FIN; IDLE->CALC on start_i; CALC->FIN after 32 iterations; FIN->IDLE unconditionally.
REQ-015 SHALL capture op_i, both operands and rd_i on the accepting edge (start_i high in IDLE); later input changes are ignored.
REQ-016 SHALL ignore start_i in CALC and FIN; no queuing.
REQ-017 SHALL assert busy_o in CALC and FIN; deasserted in IDLE.
REQ-018 SHALL perform one shift-add (multiply) or shift-subtract restoring step (divide) per CALC cycle, 32 cycles.
REQ-019 SHALL give latency of exactly 34 cycles: start accepted at edge N, done_o high during cycle N+33.
REQ-020 SHALL handle signed operands by magnitude conversion before iteration and sign correction in FIN; MULHSU treats rs1 signed, rs2 unsigned.
REQ-021 SHALL return MUL = low 32 bits; MULH/MULHSU/MULHU = high 32 bits of the 64-bit product.
REQ-022 SHALL handle divide-by-zero with no iteration (IDLE->FIN, done one cycle after accept): DIV/DIVU quotient = 0xFFFFFFFF, REM/REMU = rs1.
REQ-023 SHALL handle signed overflow (DIV/REM, rs1=0x80000000, rs2=0xFFFFFFFF) by fast path as REQ-022: DIV = 0x80000000, REM = 0.
REQ-024 SHALL give REM a result with the dividend's sign, and DIV a quotient truncated toward zero.
REQ-025 SHALL assert wen_o only with done_o and only when captured rd != 0.
REQ-026 SHALL hold result_o and rd_o at their last values outside done_o; consumers sample only on done_o.
REQ-027 SHALL accept start_i in the cycle immediately following FIN (IDLE), allowing back-to-back operations.

Reset
REQ-028 SHALL, with rst_i high at a posedge, enter IDLE and clear busy_o, done_o, wen_o, result_o, rd_o and all internal accumulators.
REQ-029 SHALL abort an operation interrupted by reset mid-CALC or in FIN without asserting wen_o, even if rst_i coincides with FIN.
REQ-030 SHALL give rst_i priority over start_i in the same cycle.

Configuration
REQ-031 SHALL, with macro MD_FAST_MUL_EN defined, compute MUL/MULH/MULHSU/MULHU with a single-cycle 64-bit multiplier (IDLE->FIN, latency 2 cycles, done at N+1); divides remain iterative.
REQ-032 SHALL, with MD_FAST_MUL_EN undefined, make all eight ops iterative per REQ-018/019; results identical bit-for-bit in both builds.

Structure
REQ-033 SHALL place in package md_pkg: the op encoding enum, the FSM state enum, XLEN and iteration count constants.
REQ-034 SHALL contain exactly one sub-module, md_div_iter (one restoring-divide step: remainder/quotient in, remainder/quotient out); multiply step stays inline.

Verification
REQ-035 SHALL cover: MUL 7 x -3, rd=5 -> done at N+33 (N+1 with MD_FAST_MUL_EN), result 0xFFFFFFEB, wen_o=1, rd_o=5.
REQ-036 SHALL cover: MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000.
REQ-037 SHALL cover: DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-038 SHALL cover: DIVU 5/0 -> 0xFFFFFFFF at N+1; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 at N+1; REM same -> 0.
REQ-039 SHALL cover: start_i held high during CALC with different operands -> only the first op completes; rd=0 op -> done_o=1, wen_o=0.
REQ-040 SHALL cover: rst_i asserted at CALC cycle 10 -> next cycle IDLE, all outputs 0, no wen_o pulse; fresh start then completes normally.
